// File: rtl/fft_bitrev_loader.sv
// Radix-2 DIT FFT input stage: buffers one frame of real samples, then emits N/2 operand
// pairs in bit-reversed order with zero imaginary parts. Define LOADER_PINGPONG_EN for two banks.
module fft_bitrev_loader #(
    parameter int WIDTH = 9,
    parameter int LOG2N = 3
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_ar,
    output logic [WIDTH-1:0] out_ai,
    output logic [WIDTH-1:0] out_br,
    output logic [WIDTH-1:0] out_bi,
    output logic [LOG2N-2:0] out_idx,
    output logic             out_last
);

    localparam int N  = 1 << LOG2N;
    localparam int KW = LOG2N - 1;
    localparam logic [LOG2N-1:0] WR_LAST = LOG2N'(N - 1);
    localparam logic [KW-1:0]    K_LAST  = {KW{1'b1}};

    logic [LOG2N-1:0] wr_cnt_reg;
    logic             wr_fire, wr_done, rd_fire, rd_done;
    logic             load_en, drop_valid;
    logic [KW-1:0]    load_k;
    logic [KW-1:0]    j;
    logic [WIDTH-1:0] a_src, b_src;
    logic             out_valid_reg;
    logic [KW-1:0]    rd_cnt_reg;
    logic [WIDTH-1:0] ar_reg, br_reg;

    assign wr_fire   = in_valid && in_ready;
    assign wr_done   = wr_fire && (wr_cnt_reg == WR_LAST);
    assign rd_fire   = out_valid_reg && out_ready;
    assign rd_done   = rd_fire && out_last;

    assign out_valid = out_valid_reg;
    assign out_idx   = rd_cnt_reg;
    assign out_last  = out_valid_reg && (rd_cnt_reg == K_LAST);
    assign out_ar    = ar_reg;
    assign out_br    = br_reg;
    assign out_ai    = '0;
    assign out_bi    = '0;

    // Pair k reads x[j] and x[j + N/2], where j is k bit-reversed over LOG2N-1 bits.
    generate
        for (genvar gi = 0; gi < KW; gi++) begin : g_bitrev
            assign j[gi] = load_k[KW-1-gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            wr_cnt_reg <= '0;
        else if (wr_fire)
            wr_cnt_reg <= wr_cnt_reg + 1'b1;
    end

`ifdef LOADER_PINGPONG_EN
    logic [WIDTH-1:0] mem [2][N];
    logic             wb_reg, rb_reg;
    logic [1:0]       full_reg;
    logic             nrb, avail, free, load_bank;

    assign in_ready = !(full_reg[0] && full_reg[1]);

    // The reader takes a bank when idle or on the accept of out_last; a bank completing on
    // this very edge counts as available so pair 0 follows the final sample with no gap.
    always_comb begin
        nrb        = rd_done ? ~rb_reg : rb_reg;
        avail      = full_reg[nrb] || (wr_done && (wb_reg == nrb));
        free       = !out_valid_reg || rd_done;
        load_en    = (free && avail) || (rd_fire && !out_last);
        load_k     = free ? '0 : rd_cnt_reg + 1'b1;
        load_bank  = free ? nrb : rb_reg;
        drop_valid = rd_done && !avail;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wb_reg <= 1'b0;
            rb_reg <= 1'b0;
        end else begin
            if (wr_done)
                wb_reg <= ~wb_reg;
            rb_reg <= nrb;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_full
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn)
                    full_reg[gi] <= 1'b0;
                else if (wr_done && (wb_reg == 1'(gi)))
                    full_reg[gi] <= 1'b1;
                else if (rd_done && (rb_reg == 1'(gi)))
                    full_reg[gi] <= 1'b0;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (wr_fire)
            mem[wb_reg][wr_cnt_reg] <= in_data;
    end

    assign a_src = mem[load_bank][{1'b0, j}];
    assign b_src = mem[load_bank][{1'b1, j}];
`else
    typedef enum logic {FILL, DRAIN} state_t;
    state_t           state_reg, state_next;
    logic [WIDTH-1:0] mem [N];

    assign in_ready = (state_reg == FILL);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            state_reg <= FILL;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        load_en    = 1'b0;
        load_k     = rd_cnt_reg + 1'b1;
        drop_valid = 1'b0;
        case (state_reg)
            FILL: begin
                if (wr_done) begin
                    state_next = DRAIN;
                    load_en    = 1'b1;
                    load_k     = '0;
                end
            end
            DRAIN: begin
                if (rd_done) begin
                    state_next = FILL;
                    drop_valid = 1'b1;
                end else if (rd_fire) begin
                    load_en = 1'b1;
                end
            end
            default: state_next = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_fire)
            mem[wr_cnt_reg] <= in_data;
    end

    assign a_src = mem[{1'b0, j}];
    assign b_src = mem[{1'b1, j}];
`endif

    // Pair 0 never needs x[N-1], so loading on the edge that writes it is safe.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid_reg <= 1'b0;
            rd_cnt_reg    <= '0;
            ar_reg        <= '0;
            br_reg        <= '0;
        end else if (load_en) begin
            out_valid_reg <= 1'b1;
            rd_cnt_reg    <= load_k;
            ar_reg        <= a_src;
            br_reg        <= b_src;
        end else if (drop_valid) begin
            out_valid_reg <= 1'b0;
            rd_cnt_reg    <= '0;
        end
    end

endmodule

// File: tb/tb_fft_bitrev_loader.sv
// Directed bench for fft_bitrev_loader (WIDTH=9, LOG2N=3); frames are fed and drained at
// falling edges, each pair checked against a bit-reversed index table.
module tb_fft_bitrev_loader;

    localparam int W = 9;
    localparam int L = 3;

    logic         clk;
    logic         rstn;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_ar, out_ai, out_br, out_bi;
    logic [L-2:0] out_idx;
    logic         out_last;

    int checks = 0;
    int errors = 0;
    int jt[4] = '{0, 2, 1, 3};

    logic signed [W-1:0] f1[8], f2[8], f3[8], fx[8];

    fft_bitrev_loader #(.WIDTH(W), .LOG2N(L)) dut (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ar(out_ar), .out_ai(out_ai), .out_br(out_br), .out_bi(out_bi),
        .out_idx(out_idx), .out_last(out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the last sample is captured.
    task automatic feed(input logic signed [W-1:0] x[8], input int duty, input bit chk_idle);
        int i = 0;
        int cyc = 0;
        while (i < 8 && cyc < 500) begin
            chk("fill_ready", in_ready, 1);
            if (chk_idle) chk("fill_idle", out_valid, 0);
            if ($urandom_range(0, 99) < duty) begin
                in_valid = 1'b1;
                in_data  = x[i];
                i++;
            end else begin
                in_valid = 1'b0;
                in_data  = W'($urandom);
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        if (i < 8) chk("feed_timeout", i, 8);
        chk("latency", out_valid, 1);
    endtask

    // Called at a falling edge; returns at the falling edge after out_last is accepted.
    task automatic drain(input logic signed [W-1:0] x[8], input bit rnd, input bit expect_now);
        int k = 0;
        int cyc = 0;
        bit rdy;
        while (k < 4 && cyc < 500) begin
            if (expect_now && cyc == 0) chk("no_bubble", out_valid, 1);
            rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid) begin
                chk("pair_a", $signed(out_ar), x[jt[k]]);
                chk("pair_b", $signed(out_br), x[jt[k] + 4]);
                chk("imag_a", out_ai, 0);
                chk("imag_b", out_bi, 0);
                chk("pair_idx", out_idx, k);
                chk("pair_last", out_last, (k == 3));
`ifndef LOADER_PINGPONG_EN
                chk("drain_busy", in_ready, 0);
                in_valid = 1'b1;
                in_data  = W'($urandom);
`endif
                if (rdy) k++;
            end
            out_ready = rdy;
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
        if (k < 4) chk("drain_timeout", k, 4);
`ifndef LOADER_PINGPONG_EN
        in_valid = 1'b0;
        chk("post_last_valid", out_valid, 0);
        chk("post_last_ready", in_ready, 1);
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired observed no finish required finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 8; i++) begin
            f1[i] = W'(i + 1);
            f2[i] = W'(i + 10);
            f3[i] = W'(i + 9);
            case (i % 4)
                0:       fx[i] = 9'h100;
                1:       fx[i] = 9'h0FF;
                2:       fx[i] = 9'h000;
                default: fx[i] = 9'h1FF;
            endcase
        end

        rstn      = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_idx", out_idx, 0);
        chk("rst_out_ar", out_ar, 0);
        chk("rst_out_br", out_br, 0);
        chk("rst_out_ai", out_ai, 0);
        chk("rst_out_bi", out_bi, 0);
        rstn = 1'b1;

        // Ordering: 1..8 -> (1,5),(3,7),(2,6),(4,8)
        feed(f1, 100, 1'b1);
        drain(f1, 1'b0, 1'b0);

        // Random backpressure
        feed(f2, 100, 1'b1);
        drain(f2, 1'b1, 1'b0);

        // Input gaps at 30% duty
        feed(f1, 30, 1'b1);
        drain(f1, 1'b0, 1'b0);

        // Signed extremes
        feed(fx, 100, 1'b1);
        drain(fx, 1'b1, 1'b0);

        // Reset in the middle of draining
        feed(f2, 100, 1'b1);
        chk("pre_rst_a", $signed(out_ar), 10);
        rstn = 1'b0;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_a", out_ar, 0);
        chk("async_rst_b", out_br, 0);
        chk("async_rst_idx", out_idx, 0);
        @(negedge clk);
        rstn = 1'b1;
        chk("rel_in_ready", in_ready, 1);
        chk("rel_out_valid", out_valid, 0);
        feed(f1, 100, 1'b1);
        drain(f1, 1'b0, 1'b0);

`ifdef LOADER_PINGPONG_EN
        // Continuous frames with full downstream throughput
        fork
            begin
                feed(f1, 100, 1'b1);
                feed(f3, 100, 1'b0);
            end
            begin
                drain(f1, 1'b0, 1'b0);
                drain(f3, 1'b0, 1'b0);
            end
        join
        chk("pp_idle_after", out_valid, 0);

        // Two frames buffered, then drained back to back without a bubble
        feed(f1, 100, 1'b1);
        feed(f3, 100, 1'b0);
        chk("pp_both_full", in_ready, 0);
        drain(f1, 1'b0, 1'b0);
        drain(f3, 1'b0, 1'b1);
        chk("pp_ready_after", in_ready, 1);
        chk("pp_valid_after", out_valid, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
